// File: rtl/isp_bayer_mosaic.sv
// RGB-to-Bayer re-mosaic: keeps the CFA-selected channel, applies a Q4.4 gain with
// round-half-up and saturation (latency 3), and checks line/frame geometry.
module isp_bayer_mosaic #(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960,
  parameter int BAYER  = 0
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic            in_de,
  input  logic [BITS-1:0] in_r,
  input  logic [BITS-1:0] in_g,
  input  logic [BITS-1:0] in_b,
  input  logic [7:0]      gain_r,
  input  logic [7:0]      gain_g,
  input  logic [7:0]      gain_b,
  output logic            out_href,
  output logic            out_vsync,
  output logic            out_de,
  output logic [BITS-1:0] out_raw,
  output logic            frame_done,
  output logic            line_err
);
  localparam logic [1:0] PHASE = 2'(BAYER);
  localparam int         PW    = BITS + 8;
  localparam logic [PW:0] MAXV = (PW+1)'((1 << BITS) - 1);

  logic [15:0]     r_pix_cnt;
  logic [15:0]     r_line_cnt;
  logic            r_prev_href;
  logic [7:0]      r_gain_r_s;
  logic [7:0]      r_gain_g_s;
  logic [7:0]      r_gain_b_s;
  logic [BITS-1:0] r_sel;
  logic [7:0]      r_gsel;
  logic [PW-1:0]   r_prod;
  logic [BITS-1:0] r_raw;
  logic [2:0]      r_href_d;
  logic [2:0]      r_vsync_d;
  logic [2:0]      r_de_d;
  logic            r_frame_done;
  logic            r_line_err;

  logic            w_fall;
  logic [1:0]      w_fmt;
  logic [BITS-1:0] w_sel;
  logic [7:0]      w_gsel;
  logic [PW:0]     w_res;
  logic [BITS-1:0] w_sat;

  always_comb begin
    w_fall = r_prev_href & ~in_href;
    // Phase uses the counter values before this cycle's update.
    w_fmt  = PHASE ^ {r_line_cnt[0], r_pix_cnt[0]};
    w_sel  = in_g;
    w_gsel = r_gain_g_s;
    if (w_fmt == 2'd0) begin
      w_sel  = in_r;
      w_gsel = r_gain_r_s;
    end else if (w_fmt == 2'd3) begin
      w_sel  = in_b;
      w_gsel = r_gain_b_s;
    end
    w_res = ({1'b0, r_prod} + (PW+1)'(8)) >> 4;
    w_sat = (w_res > MAXV) ? {BITS{1'b1}} : w_res[BITS-1:0];
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_pix_cnt    <= '0;
      r_line_cnt   <= '0;
      r_prev_href  <= 1'b0;
      r_gain_r_s   <= '0;
      r_gain_g_s   <= '0;
      r_gain_b_s   <= '0;
      r_sel        <= '0;
      r_gsel       <= '0;
      r_prod       <= '0;
      r_raw        <= '0;
      r_href_d     <= '0;
      r_vsync_d    <= '0;
      r_de_d       <= '0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
    end else begin
      r_prev_href <= in_href;
      if (in_href) begin
        if (r_pix_cnt != 16'hFFFF) r_pix_cnt <= r_pix_cnt + 16'd1;
      end else begin
        r_pix_cnt <= '0;
      end
      // Saturating line count keeps frame_done to a single pulse per frame.
      if (in_vsync) r_line_cnt <= '0;
      else if (w_fall && r_line_cnt != 16'hFFFF) r_line_cnt <= r_line_cnt + 16'd1;

      r_line_err   <= w_fall && (r_pix_cnt != 16'(WIDTH));
      r_frame_done <= w_fall && !in_vsync && (({1'b0, r_line_cnt} + 17'd1) == 17'(HEIGHT));

      if (in_vsync) begin
        r_gain_r_s <= gain_r;
        r_gain_g_s <= gain_g;
        r_gain_b_s <= gain_b;
      end

      r_sel     <= w_sel;
      r_gsel    <= w_gsel;
      r_prod    <= PW'(r_sel) * PW'(r_gsel);
      // Gate with the href stage that lands in out_href on this same edge.
      r_raw     <= r_href_d[1] ? w_sat : '0;
      r_href_d  <= {r_href_d[1:0], in_href};
      r_vsync_d <= {r_vsync_d[1:0], in_vsync};
      r_de_d    <= {r_de_d[1:0], in_de};
    end
  end

  assign out_href   = r_href_d[2];
  assign out_vsync  = r_vsync_d[2];
  assign out_de     = r_de_d[2];
  assign out_raw    = r_raw;
  assign frame_done = r_frame_done;
  assign line_err   = r_line_err;
endmodule

// File: tb/tb_isp_bayer_mosaic.sv
// Bench for isp_bayer_mosaic: three CFA phases driven in parallel, per-cycle scoreboard
// of delayed outputs plus hand-counted frame_done/line_err pulses.
module tb_isp_bayer_mosaic;
  localparam int W = 4;
  localparam int H = 2;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_href = 1'b0, in_vsync = 1'b0, in_de = 1'b0;
  logic [7:0] in_r = 8'd200, in_g = 8'd100, in_b = 8'd50;
  logic [7:0] gain_r = 8'd16, gain_g = 8'd16, gain_b = 8'd16;

  logic       o_href [3];
  logic       o_vsync[3];
  logic       o_de   [3];
  logic [7:0] o_raw  [3];
  logic       o_fd   [3];
  logic       o_le   [3];

  always #5 pclk = ~pclk;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    isp_bayer_mosaic #(
      .BITS(8), .WIDTH(W), .HEIGHT(H), .BAYER(gi == 0 ? 0 : (gi == 1 ? 3 : 1))
    ) u_dut (
      .pclk(pclk), .rst_n(rst_n),
      .in_href(in_href), .in_vsync(in_vsync), .in_de(in_de),
      .in_r(in_r), .in_g(in_g), .in_b(in_b),
      .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b),
      .out_href(o_href[gi]), .out_vsync(o_vsync[gi]), .out_de(o_de[gi]),
      .out_raw(o_raw[gi]), .frame_done(o_fd[gi]), .line_err(o_le[gi])
    );
  end

  typedef struct packed {
    logic            href;
    logic            vsync;
    logic            de;
    logic [2:0][7:0] raw;
  } exp_t;

  typedef struct {
    logic [7:0] r, g, b, gr, gg, gb, er, eg, eb;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0, bad = 0;
  int   fd_count = 0, le_count = 0;
  int   tb_pix = 0, tb_line = 0;
  logic tb_prev = 1'b0;
  logic fd_pend = 1'b0, fd_now = 1'b0, le_pend = 1'b0, le_now = 1'b0;

  function automatic int bay_of(int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 1);
  endfunction

  function automatic logic [7:0] site(int bay, int ln, int px, logic [7:0] er, logic [7:0] eg, logic [7:0] eb);
    int f;
    f = bay ^ ((ln & 1) << 1) ^ (px & 1);
    return (f == 0) ? er : ((f == 3) ? eb : eg);
  endfunction

  task automatic check(string nm, int k, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t got=%0d want=%0d", nm, k, $time, act, exp);
    end
  endtask

  // One input cycle: drive, push the expected delayed outputs, advance one clock.
  task automatic cyc(input logic rst, input logic href, input logic vsync, input logic de,
                     input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    exp_t e;
    logic fall;
    rst_n = rst; in_href = href; in_vsync = vsync; in_de = de;
    fd_now = fd_pend; le_now = le_pend;
    e = '0;
    if (!rst) begin
      for (int i = (q.size() > 2) ? q.size() - 2 : 0; i < q.size(); i++) q[i] = '0;
      tb_pix = 0; tb_line = 0; tb_prev = 1'b0; fd_pend = 1'b0; le_pend = 1'b0;
    end else begin
      fall    = tb_prev & ~href;
      fd_pend = fall & ~vsync & ((tb_line + 1) == H);
      le_pend = fall & (tb_pix != W);
      e.href = href; e.vsync = vsync; e.de = de;
      if (href) for (int k = 0; k < 3; k++) e.raw[k] = site(bay_of(k), tb_line, tb_pix, er, eg, eb);
      tb_pix = href ? tb_pix + 1 : 0;
      if (vsync) tb_line = 0;
      else if (fall) tb_line = tb_line + 1;
      tb_prev = href;
    end
    q.push_back(e);
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic line(int n, logic [7:0] er, logic [7:0] eg, logic [7:0] eb);
    repeat (n) cyc(1'b1, 1'b1, 1'b0, 1'b1, er, eg, eb);
  endtask

  task automatic frame_start();
    repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    idle(2);
  endtask

  always @(negedge pclk) begin
    if (q.size() == 4) begin
      mon_e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        check("out_href",   k, 16'(o_href[k]),  16'(mon_e.href));
        check("out_vsync",  k, 16'(o_vsync[k]), 16'(mon_e.vsync));
        check("out_de",     k, 16'(o_de[k]),    16'(mon_e.de));
        check("out_raw",    k, 16'(o_raw[k]),   16'(mon_e.raw[k]));
        check("frame_done", k, 16'(o_fd[k]),    16'(fd_now));
        check("line_err",   k, 16'(o_le[k]),    16'(le_now));
      end
      if (o_fd[0] === 1'b1) fd_count++;
      if (o_le[0] === 1'b1) le_count++;
    end
  end

  initial begin
    vec_t tbl[5];
    int   fd0, le0;
    tbl[0] = '{r:8'd100, g:8'd100, b:8'd50,  gr:8'd24,  gg:8'd16,  gb:8'd16, er:8'd150, eg:8'd100, eb:8'd50};
    tbl[1] = '{r:8'd200, g:8'd100, b:8'd50,  gr:8'd32,  gg:8'd17,  gb:8'd0,  er:8'd255, eg:8'd106, eb:8'd0};
    tbl[2] = '{r:8'd10,  g:8'd255, b:8'd255, gr:8'd16,  gg:8'd32,  gb:8'd16, er:8'd10,  eg:8'd255, eb:8'd255};
    tbl[3] = '{r:8'd1,   g:8'd3,   b:8'd7,   gr:8'd8,   gg:8'd8,   gb:8'd8,  er:8'd1,   eg:8'd2,   eb:8'd4};
    tbl[4] = '{r:8'd255, g:8'd0,   b:8'd128, gr:8'd255, gg:8'd255, gb:8'd1,  er:8'd255, eg:8'd0,   eb:8'd8};

    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    idle(2);

    // Basic two-line frame at unity gain, all three phases at once.
    fd0 = fd_count; le0 = le_count;
    frame_start();
    line(W, 8'd200, 8'd100, 8'd50); idle(2);
    line(W, 8'd200, 8'd100, 8'd50); idle(4);
    check("basic_fd_count", 0, 16'(fd_count - fd0), 16'd1);
    check("basic_le_count", 0, 16'(le_count - le0), 16'd0);
    $display("seq basic frame done");

    // de is only delayed, independent of href.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    idle(2);

    for (int v = 0; v < 5; v++) begin
      in_r = tbl[v].r; in_g = tbl[v].g; in_b = tbl[v].b;
      gain_r = tbl[v].gr; gain_g = tbl[v].gg; gain_b = tbl[v].gb;
      frame_start();
      line(W, tbl[v].er, tbl[v].eg, tbl[v].eb); idle(2);
      line(W, tbl[v].er, tbl[v].eg, tbl[v].eb); idle(2);
      $display("vec %0d applied rgb=%0d/%0d/%0d gains=%0d/%0d/%0d", v, tbl[v].r, tbl[v].g, tbl[v].b,
               tbl[v].gr, tbl[v].gg, tbl[v].gb);
    end

    // Mid-frame gain change waits for the next vsync.
    in_r = 8'd200; in_g = 8'd100; in_b = 8'd50;
    gain_r = 8'd16; gain_g = 8'd16; gain_b = 8'd16;
    frame_start();
    line(W, 8'd200, 8'd100, 8'd50); idle(1);
    gain_g = 8'd32;
    idle(1);
    line(W, 8'd200, 8'd100, 8'd50); idle(2);
    frame_start();
    line(W, 8'd200, 8'd200, 8'd50); idle(2);
    gain_g = 8'd16;
    $display("seq gain shadow done");

    // Short and long lines, and a third line past HEIGHT.
    fd0 = fd_count; le0 = le_count;
    frame_start();
    line(3, 8'd200, 8'd100, 8'd50); idle(2);
    line(5, 8'd200, 8'd100, 8'd50); idle(2);
    line(W, 8'd200, 8'd100, 8'd50); idle(4);
    check("geom_fd_count", 0, 16'(fd_count - fd0), 16'd1);
    check("geom_le_count", 0, 16'(le_count - le0), 16'd2);
    $display("seq geometry done");

    // vsync coincident with the closing href edge suppresses frame_done.
    fd0 = fd_count;
    frame_start();
    line(W, 8'd200, 8'd100, 8'd50); idle(1);
    line(W, 8'd200, 8'd100, 8'd50);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    idle(4);
    check("vsync_fall_fd_count", 0, 16'(fd_count - fd0), 16'd0);
    $display("seq vsync on falling edge done");

    // One-pixel lines from a toggling href.
    le0 = le_count;
    frame_start();
    repeat (4) begin
      line(1, 8'd200, 8'd100, 8'd50);
      idle(1);
    end
    idle(3);
    check("toggle_le_count", 0, 16'(le_count - le0), 16'd4);
    $display("seq toggling href done");

    // Reset mid-line, then a clean frame must match the basic one.
    frame_start();
    line(2, 8'd200, 8'd100, 8'd50);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    idle(3);
    fd0 = fd_count; le0 = le_count;
    frame_start();
    line(W, 8'd200, 8'd100, 8'd50); idle(2);
    line(W, 8'd200, 8'd100, 8'd50); idle(6);
    check("reset_fd_count", 0, 16'(fd_count - fd0), 16'd1);
    check("reset_le_count", 0, 16'(le_count - le0), 16'd0);
    $display("seq reset recovery done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
